div11_4_seq: RTL
================

DIV11_4_SEQ -- requirements
Module: div11_4_seq

Interface
REQ-001 Parameter DW_N, default 11, dividend width.
REQ-002 Parameter DW_D, default 4, divisor width.
REQ-003 Parameter DW_Q, default 7, output quotient width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  operand pair present.
REQ-008 in_ready  out  1  block can accept operands.
REQ-009 dividend  in  DW_N  unsigned numerator.
REQ-010 divisor  in  DW_D  unsigned denominator.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 quotient  out  DW_Q  saturated unsigned quotient.
REQ-014 remainder  out  DW_D  unsigned remainder.
REQ-015 overflow  out  1  true quotient exceeds 2^DW_Q-1.
REQ-016 div_zero  out  1  divisor was zero.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 Accept occurs on an edge with in_valid=1 and in_ready=1; the block SHALL latch the dividend and divisor at that edge and ignore the operand inputs thereafter.
REQ-020 Accept with divisor≠0 SHALL move IDLE->BUSY and load the bit counter with DW_N-1.
REQ-021 BUSY SHALL perform one restoring step per cycle, MSB first: partial remainder = {rem, next dividend bit}; if partial ≥ divisor, subtract and set quotient bit=1, else quotient bit=0.
REQ-022 The partial remainder SHALL be DW_D+1 bits wide, and the internal quotient register SHALL be a full DW_N bits wide.
REQ-023 After the step with counter=0, the FSM SHALL move BUSY->DONE, so that out_valid is first high exactly DW_N+1 (12) edges after the accept edge.
REQ-024 In DONE, if the internal quotient is greater than 2^DW_Q-1, quotient SHALL be 2^DW_Q-1 (127) and overflow SHALL be 1; otherwise quotient SHALL equal the internal value and overflow SHALL be 0.
REQ-025 remainder SHALL always be the exact remainder dividend mod divisor, including when overflow is 1.
REQ-026 Accept with divisor=0 SHALL move IDLE->DONE at the next edge with quotient=127, remainder=0, div_zero=1 and overflow=0.
REQ-027 DONE SHALL hold all outputs stable until an edge with out_ready=1, then move to IDLE; the result is not re-emitted.
REQ-028 in_valid asserted while the block is in BUSY or DONE SHALL have no effect, and the operands SHALL NOT be captured.
REQ-029 There is no same-cycle accept in DONE; a new operand pair SHALL be accepted no earlier than the edge after the result is consumed.

Reset
REQ-030 While rst=1 at an edge, the FSM SHALL enter IDLE, the counter and datapath registers SHALL clear, and the reset values SHALL be in_ready=1, out_valid=0, quotient=0, remainder=0, overflow=0 and div_zero=0.
REQ-031 Reset asserted during BUSY or DONE SHALL abort the operation, discard its result, and produce no out_valid pulse.

Structure
REQ-032 The shared package lenet_div_pkg SHALL hold the DW_N/DW_D/DW_Q defaults, the saturation constant Q_MAX=127 and the FSM state enum.
REQ-033 The block SHALL use one combinational sub-module, div_step, that takes the partial remainder, dividend bit and divisor and returns the next remainder and the quotient bit.
REQ-034 The implementation SHALL be 120-400 lines of RTL, with no multipliers or dividers inferred from the / or % operators.

Verification
REQ-035 Scenario 1: dividend=100, divisor=7 -> quotient=14, remainder=2, overflow=0, out_valid first high 12 edges after accept.
REQ-036 Scenario 2: dividend=1904, divisor=15 -> quotient=126, remainder=14, overflow=0; dividend=2047, divisor=15 -> quotient=127, remainder=7, overflow=1.
REQ-037 Scenario 3: dividend=500, divisor=0 -> out_valid one edge after accept with div_zero=1, quotient=127 and remainder=0.
REQ-038 Scenario 4: with out_ready held 0 for 20 cycles in DONE, outputs and out_valid SHALL stay stable, in_ready=0, and a pulsed in_valid SHALL be ignored; with out_ready=1, the FSM returns to IDLE on the next edge.
REQ-039 Scenario 5: rst=1 at the 5th BUSY cycle -> the next cycle shows in_ready=1, out_valid=0 and all outputs 0; a new accept of 0/5 then yields quotient=0, remainder=0.
REQ-040 Scenario 6: random back-to-back operands against a reference model (saturating quotient, exact remainder) over 10k transactions, with random out_ready stalls, SHALL produce zero mismatches.

Source files
------------

// File: rtl/lenet_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lenet_div_pkg
// Description : Shared widths, saturation constant and FSM states for the
//               sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
package lenet_div_pkg;

    localparam int DEF_DW_N = 11;
    localparam int DEF_DW_D = 4;
    localparam int DEF_DW_Q = 7;
    localparam int Q_MAX    = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div11_4_seq_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step: shift in a
//               dividend bit, conditionally subtract the divisor.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int DW_D = 4
) (
    input  logic [DW_D-1:0] i_rem,
    input  logic            i_bit,
    input  logic [DW_D-1:0] i_dvs,
    output logic [DW_D-1:0] o_rem,
    output logic            o_qbit
);

    logic [DW_D:0]   w_partial;
    logic [DW_D-1:0] w_diff;
    logic            w_ge;

    // The true difference is always below the divisor, so the low DW_D bits
    // of a modular subtraction are exact.
    assign w_partial = {i_rem, i_bit};
    assign w_ge      = (w_partial >= {1'b0, i_dvs});
    assign w_diff    = w_partial[DW_D-1:0] - i_dvs;
    assign o_rem     = w_ge ? w_diff : w_partial[DW_D-1:0];
    assign o_qbit    = w_ge;

endmodule
`default_nettype wire

// File: rtl/div11_4_seq.sv
`default_nettype none
// ============================================================================
// Module      : div11_4_seq
// Description : Valid/ready sequential restoring divider with a saturating
//               quotient, exact remainder and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module div11_4_seq
    import lenet_div_pkg::*;
#(
    parameter int DW_N = DEF_DW_N,
    parameter int DW_D = DEF_DW_D,
    parameter int DW_Q = DEF_DW_Q
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_N-1:0] dividend,
    input  logic [DW_D-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_Q-1:0] quotient,
    output logic [DW_D-1:0] remainder,
    output logic            overflow,
    output logic            div_zero
);

    localparam int              c_CW       = $clog2(DW_N);
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(DW_N - 1);
    localparam logic [DW_N-1:0] c_QMAX_N   = DW_N'((1 << DW_Q) - 1);
    localparam logic [DW_Q-1:0] c_QMAX     = {DW_Q{1'b1}};

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic              r_last;
    logic              r_zero;
    logic [DW_N-1:0]   r_dvd;
    logic [DW_N-1:0]   r_quo;
    logic [DW_D-1:0]   r_dvs;
    logic [DW_D-1:0]   r_rem;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DW_Q-1:0]   r_quotient;
    logic [DW_D-1:0]   r_remainder;
    logic              r_overflow;
    logic              r_div_zero;

    logic [DW_D-1:0]   w_rem_next;
    logic              w_qbit;
    logic              w_ovf;

    div_step #(
        .DW_D (DW_D)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd[DW_N-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    assign w_ovf = (r_quo > c_QMAX_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_zero      <= 1'b0;
            r_dvd       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_overflow  <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dvd      <= dividend;
                        r_dvs      <= divisor;
                        r_rem      <= '0;
                        r_quo      <= '0;
                        r_cnt      <= c_CNT_LOAD;
                        // A zero divisor skips the shift loop and finishes one edge later.
                        r_last     <= (divisor == '0);
                        r_zero     <= (divisor == '0);
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_last) begin
                        r_quotient  <= (w_ovf || r_zero) ? c_QMAX : r_quo[DW_Q-1:0];
                        r_remainder <= r_rem;
                        r_overflow  <= w_ovf;
                        r_div_zero  <= r_zero;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= {r_quo[DW_N-2:0], w_qbit};
                        r_dvd <= {r_dvd[DW_N-2:0], 1'b0};
                        if (r_cnt == '0) begin
                            r_last <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - c_CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign overflow  = r_overflow;
    assign div_zero  = r_div_zero;

endmodule
`default_nettype wire
